// File: rtl/mu02_acc_cpu.sv
// rtl/mu02_acc_cpu.sv - parametrised accumulator processor with program-load port and handshaked I/O
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 leave HALT and begin executing at pc=0
//   prog_we/addr/data     memory write port, honoured only while halted
//   in_port, in_valid     input word and its valid; in_ready high while an IN waits
//   out_port, out_valid   registered output word and its one-cycle update strobe
//   halted                high in HALT
//   flags                 {V,C,N,Z}
//   pc_dbg                current program counter
module mu02_acc_cpu #(
  parameter int DW          = 16,
  parameter int AW          = 12,
  parameter bit BOOT_HALTED = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  input  logic [DW-1:0] in_port,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_port,
  output logic          out_valid,
  output logic          halted,
  output logic [3:0]    flags,
  output logic [AW-1:0] pc_dbg
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_WAIT_IN = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_STO  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JGE  = 4'h5;
  localparam logic [3:0] OP_JNE  = 4'h6;
  localparam logic [3:0] OP_STP  = 4'h7;
  localparam logic [3:0] OP_LDAI = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_SUBI = 4'hB;
  localparam logic [3:0] OP_IN   = 4'hC;
  localparam logic [3:0] OP_AND  = 4'hD;
  localparam logic [3:0] OP_INC  = 4'hE;
  localparam logic [3:0] OP_DEC  = 4'hF;

  logic [DW-1:0] mem [0:(2**AW)-1];

  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic [DW-1:0] ir;

  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic [DW-1:0] mem_m;
  logic [DW-1:0] imm;

  assign opcode  = ir[DW-1 -: 4];
  assign operand = ir[AW-1:0];
  assign mem_m   = mem[operand];
  assign imm     = {{(DW-AW){operand[AW-1]}}, operand};

  assign in_ready = (state == S_WAIT_IN);
  assign halted   = (state == S_HALT);
  assign pc_dbg   = pc;

  // ALU: every acc-writing opcode resolves to one result plus C/V; add and
  // subtract share a single DW+1-bit adder so bit DW is carry or borrow.
  logic [DW:0]   alu_wide;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic          alu_sub;
  logic          alu_arith;
  logic          alu_c;
  logic          alu_v;
  logic          writes_acc;

  always_comb begin
    alu_b      = mem_m;
    alu_res    = mem_m;
    alu_sub    = 1'b0;
    alu_arith  = 1'b0;
    writes_acc = 1'b1;
    case (opcode)
      OP_LDA:  alu_res = mem_m;
      OP_LDAI: alu_res = imm;
      OP_AND:  alu_res = acc & mem_m;
      OP_ADD:  begin alu_arith = 1'b1; alu_b = mem_m; end
      OP_SUB:  begin alu_arith = 1'b1; alu_b = mem_m; alu_sub = 1'b1; end
      OP_ADDI: begin alu_arith = 1'b1; alu_b = imm; end
      OP_SUBI: begin alu_arith = 1'b1; alu_b = imm; alu_sub = 1'b1; end
      OP_INC:  begin alu_arith = 1'b1; alu_b = DW'(1); end
      OP_DEC:  begin alu_arith = 1'b1; alu_b = DW'(1); alu_sub = 1'b1; end
      default: writes_acc = 1'b0;
    endcase
    alu_wide = alu_sub ? ({1'b0, acc} - {1'b0, alu_b}) : ({1'b0, acc} + {1'b0, alu_b});
    if (alu_arith) alu_res = alu_wide[DW-1:0];
    alu_c = alu_arith & alu_wide[DW];
    // Overflow: operands' signs agree (add) or differ (sub) and the result sign flips from acc.
    alu_v = alu_arith
          & (alu_sub ? (acc[DW-1] != alu_b[DW-1]) : (acc[DW-1] == alu_b[DW-1]))
          & (alu_res[DW-1] != acc[DW-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT_HALTED ? S_HALT : S_FETCH;
      pc        <= '0;
      acc       <= '0;
      ir        <= '0;
      flags     <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= mem[pc];
          pc    <= pc + AW'(1);
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (writes_acc) begin
            acc   <= alu_res;
            flags <= {alu_v, alu_c, alu_res[DW-1], (alu_res == '0)};
          end
          case (opcode)
            OP_JMP: pc <= operand;
            OP_JGE: if (!acc[DW-1]) pc <= operand;
            OP_JNE: if (acc != '0) pc <= operand;
            OP_STP: state <= S_HALT;
            OP_IN:  state <= S_WAIT_IN;
            OP_OUT: begin
              out_port  <= acc;
              out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            acc   <= in_port;
            flags <= {2'b00, in_port[DW-1], (in_port == '0)};
            state <= S_FETCH;
          end
        end
        default: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
      endcase
    end
  end

  // Program loads only happen in HALT and STO only in EXEC, so the two never collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_HALT && prog_we)
        mem[prog_addr] <= prog_data;
      else if (state == S_EXEC && opcode == OP_STO)
        mem[operand] <= acc;
    end
  end

endmodule
